// File: rtl/axi_write_master_pkg.sv
// Shared types for the c0_s1 AXI write initiator: FSM encoding, BRESP codes, default widths.
package sw_axi_pkg;

    localparam int DEF_ID_WIDTH   = 8;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 256;
    localparam int LEN_WIDTH      = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } wr_state_e;

    typedef enum logic [1:0] {
        BRESP_OKAY   = 2'b00,
        BRESP_EXOKAY = 2'b01,
        BRESP_SLVERR = 2'b10,
        BRESP_DECERR = 2'b11
    } bresp_e;

endpackage

// File: rtl/axi_write_master_beat_counter.sv
// Beat counter plus last-beat compare for one AXI write burst; kept separate so a
// multi-port write arbiter can reuse it per port.
module axi_wr_beat_counter
    import sw_axi_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 inc_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    output logic                 last_o
);

    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)      cnt_d = '0;
        else if (inc_i) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign last_o = (cnt_q == len_i);

endmodule

// File: rtl/axi_write_master.sv
// Single-burst AXI write initiator (AW/W/B) for the c0_s1 path.
// Define AXI_WR_RESP_CHECK_EN to enable BID checking and the sticky error output.
module axi_write_master
    import sw_axi_pkg::*;
#(
    parameter int ID_WIDTH   = DEF_ID_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   wr_id_in,
    input  logic [ADDR_WIDTH-1:0] wr_addr_in,
    input  logic [LEN_WIDTH-1:0]  wr_len_in,
    input  logic                  wr_info_valid_in,
    output logic                  wr_info_rdy_out,
    input  logic [DATA_WIDTH-1:0] wr_data_in,
    input  logic                  wr_data_valid_in,
    output logic                  wr_data_rdy_out,
    input  logic                  axi_awready_in,
    output logic [ID_WIDTH-1:0]   axi_awid_out,
    output logic [ADDR_WIDTH-1:0] axi_awaddr_out,
    output logic [LEN_WIDTH-1:0]  axi_awlen_out,
    output logic                  axi_awvalid_out,
    input  logic                  axi_wready_in,
    output logic [DATA_WIDTH-1:0] axi_wdata_out,
    output logic                  axi_wlast_out,
    output logic                  axi_wvalid_out,
    input  logic [ID_WIDTH-1:0]   axi_bid_in,
    input  logic [1:0]            axi_bresp_in,
    input  logic                  axi_bvalid_in,
    output logic                  axi_bready_out,
`ifdef AXI_WR_RESP_CHECK_EN
    output logic                  wr_err_sticky_out,
`endif
    output logic                  wr_done_valid_out,
    output logic [1:0]            wr_done_resp_out
);

    wr_state_e             state_q, state_d;
    logic [ID_WIDTH-1:0]   awid_q, awid_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [LEN_WIDTH-1:0]  awlen_q, awlen_d;
    logic                  done_q, done_d;
    logic [1:0]            resp_q, resp_d;
    logic                  in_data, w_hs, accept, last_beat;

    assign in_data = (state_q == ST_DATA);
    assign w_hs    = in_data && wr_data_valid_in && axi_wready_in;
    // No new descriptor while the done pulse of the previous burst is still out.
    assign accept  = (state_q == ST_IDLE) && !done_q && wr_info_valid_in;

`ifdef AXI_WR_RESP_CHECK_EN
    logic err_q, err_d;
    logic bid_bad;
    assign bid_bad = (axi_bid_in != awid_q);
`else
    logic unused_bid;
    assign unused_bid = ^axi_bid_in;
`endif

    axi_wr_beat_counter u_beat_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (accept),
        .inc_i  (w_hs),
        .len_i  (awlen_q),
        .last_o (last_beat)
    );

    always_comb begin
        state_d  = state_q;
        awid_d   = awid_q;
        awaddr_d = awaddr_q;
        awlen_d  = awlen_q;
        done_d   = 1'b0;
        resp_d   = resp_q;
`ifdef AXI_WR_RESP_CHECK_EN
        err_d    = err_q;
`endif
        case (state_q)
            ST_IDLE: if (accept) begin
                awid_d   = wr_id_in;
                awaddr_d = wr_addr_in;
                awlen_d  = wr_len_in;
                state_d  = ST_ADDR;
            end
            ST_ADDR: if (axi_awready_in) state_d = ST_DATA;
            ST_DATA: if (w_hs && last_beat) state_d = ST_RESP;
            ST_RESP: if (axi_bvalid_in) begin
                done_d  = 1'b1;
                resp_d  = axi_bresp_in;
`ifdef AXI_WR_RESP_CHECK_EN
                if (bid_bad) begin
                    resp_d = BRESP_SLVERR;
                    err_d  = 1'b1;
                end
`endif
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            awid_q   <= '0;
            awaddr_q <= '0;
            awlen_q  <= '0;
            done_q   <= 1'b0;
            resp_q   <= BRESP_OKAY;
`ifdef AXI_WR_RESP_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            awid_q   <= awid_d;
            awaddr_q <= awaddr_d;
            awlen_q  <= awlen_d;
            done_q   <= done_d;
            resp_q   <= resp_d;
`ifdef AXI_WR_RESP_CHECK_EN
            err_q    <= err_d;
`endif
        end
    end

    // rst_n gates the IDLE ready so every ready/valid is low while reset is held.
    assign wr_info_rdy_out   = rst_n && (state_q == ST_IDLE) && !done_q;
    assign axi_awvalid_out   = (state_q == ST_ADDR);
    assign axi_awid_out      = awid_q;
    assign axi_awaddr_out    = awaddr_q;
    assign axi_awlen_out     = awlen_q;
    assign axi_wvalid_out    = in_data && wr_data_valid_in;
    assign wr_data_rdy_out   = in_data && axi_wready_in;
    assign axi_wdata_out     = wr_data_in;
    assign axi_wlast_out     = in_data && last_beat;
    assign axi_bready_out    = (state_q == ST_RESP);
    assign wr_done_valid_out = done_q;
    assign wr_done_resp_out  = resp_q;
`ifdef AXI_WR_RESP_CHECK_EN
    assign wr_err_sticky_out = err_q;
`endif

endmodule

// File: tb/tb_axi_write_master.sv
// Bench for axi_write_master: directed burst table plus randomized bursts against a burst-level model.
module tb_axi_write_master;

    localparam int IW = 8;
    localparam int AW = 32;
    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [IW-1:0] wr_id_in;
    logic [AW-1:0] wr_addr_in;
    logic [7:0]    wr_len_in;
    logic          wr_info_valid_in, wr_info_rdy_out;
    logic [DW-1:0] wr_data_in;
    logic          wr_data_valid_in, wr_data_rdy_out;
    logic          axi_awready_in, axi_awvalid_out;
    logic [IW-1:0] axi_awid_out;
    logic [AW-1:0] axi_awaddr_out;
    logic [7:0]    axi_awlen_out;
    logic          axi_wready_in, axi_wlast_out, axi_wvalid_out;
    logic [DW-1:0] axi_wdata_out;
    logic [IW-1:0] axi_bid_in;
    logic [1:0]    axi_bresp_in;
    logic          axi_bvalid_in, axi_bready_out;
    logic          wr_done_valid_out;
    logic [1:0]    wr_done_resp_out;
`ifdef AXI_WR_RESP_CHECK_EN
    logic          wr_err_sticky_out;
`endif

    always #5 clk = ~clk;

    axi_write_master dut (
        .clk(clk), .rst_n(rst_n),
        .wr_id_in(wr_id_in), .wr_addr_in(wr_addr_in), .wr_len_in(wr_len_in),
        .wr_info_valid_in(wr_info_valid_in), .wr_info_rdy_out(wr_info_rdy_out),
        .wr_data_in(wr_data_in), .wr_data_valid_in(wr_data_valid_in), .wr_data_rdy_out(wr_data_rdy_out),
        .axi_awready_in(axi_awready_in), .axi_awid_out(axi_awid_out), .axi_awaddr_out(axi_awaddr_out),
        .axi_awlen_out(axi_awlen_out), .axi_awvalid_out(axi_awvalid_out),
        .axi_wready_in(axi_wready_in), .axi_wdata_out(axi_wdata_out), .axi_wlast_out(axi_wlast_out),
        .axi_wvalid_out(axi_wvalid_out),
        .axi_bid_in(axi_bid_in), .axi_bresp_in(axi_bresp_in), .axi_bvalid_in(axi_bvalid_in),
        .axi_bready_out(axi_bready_out),
`ifdef AXI_WR_RESP_CHECK_EN
        .wr_err_sticky_out(wr_err_sticky_out),
`endif
        .wr_done_valid_out(wr_done_valid_out), .wr_done_resp_out(wr_done_resp_out)
    );

    typedef struct {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [7:0]    len;
        int            aw_delay;
        bit            gaps;
        logic [1:0]    bresp;
        logic [IW-1:0] bid;
        int            abort_at;   // beats completed before reset is pulsed; -1 = none
        logic [1:0]    exp_resp;
    } vec_t;

    int checks = 0;
    int errors = 0;
    bit exp_sticky = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Completion code the block should report for a burst.
    function automatic logic [1:0] model_resp(input logic [IW-1:0] id, input logic [IW-1:0] bid,
                                              input logic [1:0] bresp);
`ifdef AXI_WR_RESP_CHECK_EN
        if (bid != id) return 2'b10;
`endif
        return bresp;
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_awvalid"}, axi_awvalid_out, 0);
        chk({tag, "_wvalid"},  axi_wvalid_out, 0);
        chk({tag, "_wlast"},   axi_wlast_out, 0);
        chk({tag, "_drdy"},    wr_data_rdy_out, 0);
        chk({tag, "_bready"},  axi_bready_out, 0);
        chk({tag, "_done"},    wr_done_valid_out, 0);
        chk({tag, "_resp"},    wr_done_resp_out, 0);
        chk({tag, "_awid"},    axi_awid_out, 0);
        chk({tag, "_awaddr"},  axi_awaddr_out, 0);
        chk({tag, "_awlen"},   axi_awlen_out, 0);
`ifdef AXI_WR_RESP_CHECK_EN
        chk({tag, "_sticky"},  wr_err_sticky_out, 0);
`endif
    endtask

    task automatic run_burst(input vec_t v);
        logic [DW-1:0] beats[$];
        int cyc, k, dly;
        bit dv, wr;
        for (int i = 0; i <= int'(v.len); i++)
            beats.push_back({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});

        // Descriptor phase; beats offered here must be stalled.
        @(negedge clk);
        wr_info_valid_in = 1'b1; wr_id_in = v.id; wr_addr_in = v.addr; wr_len_in = v.len;
        wr_data_valid_in = 1'b1; axi_wready_in = 1'b1; axi_awready_in = 1'b0;
        #1;
        cyc = 0;
        while (!wr_info_rdy_out && cyc < 50) begin
            @(negedge clk); #1; cyc++;
        end
        chk("info_rdy", wr_info_rdy_out, 1);
        chk("pre_drdy", wr_data_rdy_out, 0);
        chk("pre_awvalid", axi_awvalid_out, 0);

        // Address phase; descriptor inputs scrambled to prove the fields were latched.
        for (int c = 0; c <= v.aw_delay; c++) begin
            @(negedge clk);
            wr_id_in = IW'($urandom); wr_addr_in = $urandom; wr_len_in = 8'($urandom);
            axi_awready_in = (c == v.aw_delay);
            #1;
            chk("awvalid", axi_awvalid_out, 1);
            chk("awid", axi_awid_out, v.id);
            chk("awaddr", axi_awaddr_out, v.addr);
            chk("awlen", axi_awlen_out, v.len);
            chk("info_stall", wr_info_rdy_out, 0);
            chk("w_before_aw", axi_wvalid_out, 0);
        end

        // Data phase.
        k = 0; cyc = 0;
        while (k <= int'(v.len) && cyc < 2000) begin
            @(negedge clk);
            wr_info_valid_in = 1'b0; axi_awready_in = 1'b0;
            dv = v.gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            wr = v.gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            wr_data_valid_in = dv; axi_wready_in = wr;
            wr_data_in = dv ? beats[k] : {8{$urandom}};
            #1;
            cyc++;
            if (v.abort_at >= 0 && k == v.abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("abort_info_rdy", wr_info_rdy_out, 0);
                chk_idle_outputs("abort");
                exp_sticky = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                wr_data_valid_in = 1'b0;
                return;
            end
            chk("awvalid_low", axi_awvalid_out, 0);
            chk("wvalid", axi_wvalid_out, dv);
            chk("drdy", wr_data_rdy_out, wr);
            chk("wlast", axi_wlast_out, (k == int'(v.len)));
            if (axi_wvalid_out && axi_wready_in) begin
                chk("wdata", axi_wdata_out, beats[k]);
                k++;
            end
        end
        chk("beat_count", k, int'(v.len) + 1);

        // Response phase; further beats must be stalled.
        dly = $urandom_range(0, 3);
        for (int c = 0; c <= dly; c++) begin
            @(negedge clk);
            wr_data_valid_in = 1'b1; axi_wready_in = 1'b1;
            axi_bvalid_in = (c == dly); axi_bresp_in = v.bresp; axi_bid_in = v.bid;
            #1;
            chk("bready", axi_bready_out, 1);
            chk("resp_wvalid", axi_wvalid_out, 0);
            chk("early_done", wr_done_valid_out, 0);
        end
        @(negedge clk);
        axi_bvalid_in = 1'b0; wr_data_valid_in = 1'b0;
        wr_info_valid_in = 1'b1; wr_len_in = 8'd0;
        #1;
        if (v.bid != v.id) begin
`ifdef AXI_WR_RESP_CHECK_EN
            exp_sticky = 1'b1;
`endif
        end
        chk("done", wr_done_valid_out, 1);
        chk("done_resp", wr_done_resp_out, v.exp_resp);
        chk("done_blocks_info", wr_info_rdy_out, 0);
        @(negedge clk);
        wr_info_valid_in = 1'b0;
        #1;
        chk("done_once", wr_done_valid_out, 0);
        chk("post_awvalid", axi_awvalid_out, 0);
        chk("info_rdy_again", wr_info_rdy_out, 1);
`ifdef AXI_WR_RESP_CHECK_EN
        chk("sticky", wr_err_sticky_out, exp_sticky);
`endif
    endtask

    vec_t tbl[9];
    vec_t rv;

    initial begin
        rst_n = 1'b0;
        wr_id_in = '0; wr_addr_in = '0; wr_len_in = '0; wr_info_valid_in = 1'b0;
        wr_data_in = '0; wr_data_valid_in = 1'b0; axi_awready_in = 1'b0; axi_wready_in = 1'b0;
        axi_bid_in = '0; axi_bresp_in = '0; axi_bvalid_in = 1'b0;

        //        id     addr           len    awd gaps bresp  bid    abort exp_resp
        tbl[0] = '{8'd3,  32'h0000_1000, 8'd0,   0, 0, 2'b00, 8'd3,  -1, 2'b00};
        tbl[1] = '{8'd7,  32'h0000_2000, 8'd3,   5, 0, 2'b01, 8'd7,  -1, 2'b01};
        tbl[2] = '{8'd9,  32'h0000_3000, 8'd15,  1, 1, 2'b00, 8'd9,  -1, 2'b00};
        tbl[3] = '{8'd1,  32'h0000_4000, 8'd1,   0, 0, 2'b10, 8'd1,  -1, 2'b10};
        tbl[4] = '{8'd2,  32'h0000_5020, 8'd2,   0, 1, 2'b11, 8'd2,  -1, 2'b11};
`ifdef AXI_WR_RESP_CHECK_EN
        tbl[5] = '{8'd3,  32'h0000_1000, 8'd0,   0, 0, 2'b00, 8'd5,  -1, 2'b10};
`else
        tbl[5] = '{8'd3,  32'h0000_1000, 8'd0,   0, 0, 2'b00, 8'd5,  -1, 2'b00};
`endif
        tbl[6] = '{8'd4,  32'h0000_6000, 8'd7,   0, 0, 2'b00, 8'd4,   2, 2'b00};
        tbl[7] = '{8'd6,  32'h0000_7000, 8'd4,   2, 1, 2'b00, 8'd6,  -1, 2'b00};
        tbl[8] = '{8'hFF, 32'hFFFF_FFE0, 8'd255, 0, 0, 2'b01, 8'hFF, -1, 2'b01};

        #1;
        chk("rst_info_rdy", wr_info_rdy_out, 0);
        chk_idle_outputs("rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_rel_info_rdy", wr_info_rdy_out, 1);

        foreach (tbl[i]) run_burst(tbl[i]);

        for (int n = 0; n < 25; n++) begin
            rv.id       = IW'($urandom);
            rv.addr     = $urandom & 32'hFFFF_FFE0;
            rv.len      = 8'($urandom_range(0, 20));
            rv.aw_delay = $urandom_range(0, 4);
            rv.gaps     = 1'($urandom_range(0, 1));
            rv.bresp    = 2'($urandom);
            rv.bid      = ($urandom_range(0, 7) == 0) ? IW'($urandom) : rv.id;
            rv.abort_at = -1;
            rv.exp_resp = model_resp(rv.id, rv.bid, rv.bresp);
            run_burst(rv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_write_master.md
Name: axi_write_master

Overview:
- Single-port AXI write-channel initiator for the DDR3 c0_s1 write path. It is the write-side counterpart of the read arbiter port.
- Accepts a burst descriptor (id, byte address, length) and a stream of 256-bit beats from an engine. Drives AW, W and B channels, one burst in flight at a time.
- Reports per-burst completion with the write response.
- Sits between the result/writeback logic of the engine and the c0_s1_axi_aw*/w*/b* top-level ports.

Parameters:
- ID_WIDTH, 8, AXI ID width
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 256, beat width; wstrb width is DATA_WIDTH/8

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_id_in  in  ID_WIDTH  burst ID
- wr_addr_in  in  ADDR_WIDTH  byte start address, 32-byte aligned
- wr_len_in  in  8  beats minus 1
- wr_info_valid_in  in  1  descriptor valid
- wr_info_rdy_out  out  1  descriptor accepted
- wr_data_in  in  DATA_WIDTH  write beat
- wr_data_valid_in  in  1  beat valid
- wr_data_rdy_out  out  1  beat accepted
- axi_awready_in  in  1  AXI AWREADY
- axi_awid_out  out  ID_WIDTH  AXI AWID
- axi_awaddr_out  out  ADDR_WIDTH  AXI AWADDR
- axi_awlen_out  out  8  AXI AWLEN
- axi_awvalid_out  out  1  AXI AWVALID
- axi_wready_in  in  1  AXI WREADY
- axi_wdata_out  out  DATA_WIDTH  AXI WDATA
- axi_wlast_out  out  1  AXI WLAST
- axi_wvalid_out  out  1  AXI WVALID
- axi_bid_in  in  ID_WIDTH  AXI BID
- axi_bresp_in  in  2  AXI BRESP
- axi_bvalid_in  in  1  AXI BVALID
- axi_bready_out  out  1  AXI BREADY
- wr_done_valid_out  out  1  one-cycle completion pulse
- wr_done_resp_out  out  2  completion response code

Behaviour:
- Reset: FSM to IDLE; beat counter 0; all valid/ready/done outputs 0; awid/awaddr/awlen/resp regs 0.
- Mid-burst reset aborts immediately. No partial burst is completed.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - wr_info_rdy_out=1.
  - On wr_info_valid_in, latch id/addr/len into AW registers, clear beat counter, go to ADDR.
  - awvalid rises the cycle after the descriptor is accepted.
- ADDR:
  - axi_awvalid_out=1; AW fields stable until accepted.
  - On awready, go to DATA.
- DATA:
  - axi_wvalid_out = wr_data_valid_in.
  - wr_data_rdy_out = axi_wready_in.
  - axi_wdata_out = wr_data_in (combinational passthrough, zero latency).
  - axi_wlast_out = (beat_cnt == latched len) when in DATA.
  - Beat counter increments on wvalid&wready.
  - On the handshake with wlast, go to RESP.
  - len=0 gives a single beat with wlast set.
- RESP:
  - axi_bready_out=1.
  - On bvalid: wr_done_valid_out=1 for one cycle (registered, next cycle), wr_done_resp_out=bresp. Then return to IDLE.
  - The next descriptor can be accepted the cycle after the done pulse.
- Beats arriving outside DATA are stalled (rdy=0). Descriptor valid outside IDLE is stalled.
- Beat counter is 8 bits and never wraps within a legal burst of 256 beats max.
- Constant outputs (awsize, awburst, wstrb, ...) stay at the top level, not in this block.

Optional Feature:
- Macro: AXI_WR_RESP_CHECK_EN.
- When defined: in RESP, if bid differs from the latched awid, wr_done_resp_out is forced to 2'b10 (SLVERR) regardless of bresp. A sticky error flag is held until reset; it is exposed via wr_err_sticky_out (1 bit, reset 0).
- When undefined: bid is ignored, bresp passes through unchanged, and the port is absent.

Decomposition:
- Shared package (sw_axi_pkg): FSM state encoding, BRESP codes (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3), default widths.
- No sub-module needed. Optionally split out axi_wr_beat_counter (counter plus last compare) if reused by a future multi-port write arbiter.

Test Plan:
- Single beat: descriptor id=3, addr=0x1000, len=0, data 0xA5..; awready=1, wready=1, bvalid with bresp=0 -> one AW (awlen=0), one W with wlast=1, done pulse with resp=0.
- 4-beat burst with awready held low 5 cycles -> awvalid held steady with fields unchanged; no W beats before the AW handshake; wlast only on beat 4.
- 16-beat burst with wready toggling and wr_data_valid gaps -> exactly 16 handshakes, data order preserved, wlast on beat 16.
- bresp=2'b10 -> wr_done_resp_out=2'b10; second descriptor is accepted only after the done pulse.
- rst_n asserted mid-DATA after 2 of 8 beats -> all valids and readies 0 asynchronously; after release, a fresh burst runs cleanly.
- AXI_WR_RESP_CHECK_EN defined, bid=5 vs awid=3 -> resp=2'b10 and wr_err_sticky_out=1 until reset.
